// File: rtl/risc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : risc_sequencer
// Brief   : VeriRISC 8-phase sequencer with sticky halt and a saturating
//           retired-instruction counter. Optional macro STEP_EN adds
//           step_mode/step single-step inputs.
// Revision: 1.0 - initial release
// ============================================================================
module risc_sequencer #(
  parameter int OPC_W  = 3,
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_,
`ifdef STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  input  logic [OPC_W-1:0]  opcode,
  input  logic              zero,
  output logic              sel,
  output logic              rd,
  output logic              ld_ir,
  output logic              inc_pc,
  output logic              ld_pc,
  output logic              ld_ac,
  output logic              wr,
  output logic              data_e,
  output logic              halt,
  output logic [2:0]        phase,
  output logic [ICNT_W-1:0] icnt
);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SKZ = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_STO = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(7);

  phase_e              phase_q, phase_d;
  logic                halted_q, halted_d;
  logic [ICNT_W-1:0]   icnt_q, icnt_d;

  logic w_gate;
  logic w_advance;
  logic w_aluop;

  // w_gate qualifies both phase advance and the one-shot load/write strobes.
`ifdef STEP_EN
  assign w_gate = step_mode ? step : 1'b1;
`else
  assign w_gate = 1'b1;
`endif

  assign w_advance = ~halted_q & w_gate;
  assign w_aluop   = (opcode == OP_ADD) | (opcode == OP_AND) |
                     (opcode == OP_XOR) | (opcode == OP_LDA);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      phase_q  <= PH_INST_ADDR;
      halted_q <= 1'b0;
      icnt_q   <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      icnt_q   <= icnt_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    icnt_d   = icnt_q;
    if (w_advance) begin
      phase_d = phase_e'(phase_q + 3'd1);
      if (phase_q == PH_OP_ADDR && opcode == OP_HLT) begin
        halted_d = 1'b1;
      end
      // HLT never reaches PH_STORE, so it is never counted.
      if (phase_q == PH_STORE && icnt_q != {ICNT_W{1'b1}}) begin
        icnt_d = icnt_q + ICNT_W'(1);
      end
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    if (!halted_q) begin
      case (phase_q)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = w_gate;
        end
        PH_OP_ADDR: begin
          inc_pc = w_gate;
        end
        PH_OP_FETCH: begin
          rd = w_aluop;
        end
        PH_ALU_OP: begin
          rd     = w_aluop;
          inc_pc = (opcode == OP_SKZ) & zero & w_gate;
          ld_pc  = (opcode == OP_JMP) & w_gate;
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = w_aluop;
          ld_ac  = w_aluop & w_gate;
          ld_pc  = (opcode == OP_JMP) & w_gate;
          wr     = (opcode == OP_STO) & w_gate;
          data_e = (opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign halt  = halted_q;
  assign phase = phase_q;
  assign icnt  = icnt_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_risc_sequencer
// Brief   : Vector table, directed corner sequences and random instruction
//           streams for risc_sequencer (default and ICNT_W=2 instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_risc_sequencer;

  logic        clk = 1'b0;
  logic        rst_;
  logic [2:0]  opcode;
  logic        zero;
`ifdef STEP_EN
  logic        step_mode;
  logic        step;
`endif

  logic        sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0]  phase;
  logic [15:0] icnt;

  logic        s_sel, s_rd, s_ld_ir, s_inc_pc, s_ld_pc, s_ld_ac, s_wr, s_data_e, s_halt;
  logic [2:0]  s_phase;
  logic [1:0]  s_icnt;

  always #5 clk = ~clk;

  risc_sequencer #(.OPC_W(3), .ICNT_W(16)) dut (
    .clk(clk), .rst_(rst_),
`ifdef STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .opcode(opcode), .zero(zero),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt),
    .phase(phase), .icnt(icnt)
  );

  risc_sequencer #(.OPC_W(3), .ICNT_W(2)) dut_sat (
    .clk(clk), .rst_(rst_),
`ifdef STEP_EN
    .step_mode(step_mode), .step(step),
`endif
    .opcode(opcode), .zero(zero),
    .sel(s_sel), .rd(s_rd), .ld_ir(s_ld_ir), .inc_pc(s_inc_pc), .ld_pc(s_ld_pc),
    .ld_ac(s_ld_ac), .wr(s_wr), .data_e(s_data_e), .halt(s_halt),
    .phase(s_phase), .icnt(s_icnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: phase number, sticky halt, instructions retired.
  int m_ph;
  bit m_halted;
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
  function automatic logic [8:0] strobes();
    return {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  function automatic logic [8:0] model_out(input int ph, input int op, input bit z, input bit h);
    bit aluop;
    if (h) return 9'b000000001;
    aluop = (op >= 2 && op <= 5);
    return { ph < 4,
             (ph >= 1 && ph <= 3) || (ph >= 5 && aluop),
             ph == 2 || ph == 3,
             ph == 4 || (ph == 6 && op == 1 && z),
             ph >= 6 && op == 7,
             ph == 7 && aluop,
             ph == 7 && op == 6,
             ph >= 6 && op == 6,
             1'b0 };
  endfunction

  task automatic model_clock(input int op);
    if (!m_halted) begin
      if (m_ph == 4 && op == 0) m_halted = 1'b1;
      if (m_ph == 7) m_cnt++;
      m_ph = (m_ph + 1) % 8;
    end
  endtask

  task automatic run_cycle(input int op, input bit z);
    opcode = 3'(op);
    zero   = z;
    #1;
    chk("model_phase", 32'(phase), 32'(m_ph));
    chk("model_strobes", 32'(strobes()), 32'(model_out(m_ph, op, z, m_halted)));
    chk("model_icnt", 32'(icnt), 32'(m_cnt));
    chk("model_icnt_sat", 32'(s_icnt), 32'((m_cnt > 3) ? 3 : m_cnt));
    @(posedge clk);
    model_clock(op);
    #1;
  endtask

  task automatic run_instr(input int op, input bit z);
    for (int p = 0; p < 8; p++) run_cycle(op, z);
  endtask

  task automatic do_reset();
    opcode = 3'($urandom_range(0, 7));
    zero   = 1'($urandom_range(0, 1));
    rst_   = 1'b0;
    #1;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'(9'b100000000));
    chk("rst_icnt", 32'(icnt), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold_phase", 32'(phase), 32'd0);
    #1;
    rst_ = 1'b1;
    m_ph = 0; m_halted = 1'b0; m_cnt = 0;
  endtask

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [2:0] ph;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] op;
    logic       z;
    logic [8:0] s5, s6, s7;
  } instr_t;

  vec_t   vecs[$];
  instr_t instrs[$];
  logic [8:0] common[5];

  initial begin
    rst_ = 1'b1; opcode = '0; zero = 1'b0;
`ifdef STEP_EN
    step_mode = 1'b0; step = 1'b0;
`endif
    common[0] = 9'b100000000; common[1] = 9'b110000000; common[2] = 9'b111000000;
    common[3] = 9'b111000000; common[4] = 9'b000100000;
    instrs.push_back('{3'd5, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000}); // LDA
    instrs.push_back('{3'd6, 1'b0, 9'b000000000, 9'b000000010, 9'b000000110}); // STO
    instrs.push_back('{3'd1, 1'b1, 9'b000000000, 9'b000100000, 9'b000000000}); // SKZ z=1
    instrs.push_back('{3'd1, 1'b0, 9'b000000000, 9'b000000000, 9'b000000000}); // SKZ z=0
    instrs.push_back('{3'd7, 1'b0, 9'b000000000, 9'b000010000, 9'b000010000}); // JMP
    instrs.push_back('{3'd2, 1'b1, 9'b010000000, 9'b010000000, 9'b010001000}); // ADD
    instrs.push_back('{3'd4, 1'b0, 9'b010000000, 9'b010000000, 9'b010001000}); // XOR
    foreach (instrs[k]) begin
      for (int p = 0; p < 5; p++) vecs.push_back('{instrs[k].op, instrs[k].z, 3'(p), common[p]});
      vecs.push_back('{instrs[k].op, instrs[k].z, 3'd5, instrs[k].s5});
      vecs.push_back('{instrs[k].op, instrs[k].z, 3'd6, instrs[k].s6});
      vecs.push_back('{instrs[k].op, instrs[k].z, 3'd7, instrs[k].s7});
    end
    #2;

    do_reset();
    foreach (vecs[i]) begin
      opcode = vecs[i].op;
      zero   = vecs[i].z;
      #1;
      chk("vec_phase", 32'(phase), 32'(vecs[i].ph));
      chk("vec_strobes", 32'(strobes()), 32'(vecs[i].exp));
      @(posedge clk);
      #1;
    end
    chk("vec_icnt", 32'(icnt), 32'(instrs.size()));

    // HLT after one LDA: halted, frozen at phase 5, icnt held at 1.
    do_reset();
    run_instr(5, 1'b0);
    for (int p = 0; p < 5; p++) run_cycle(0, 1'b0);
    chk("hlt_flag", 32'(halt), 32'd1);
    chk("hlt_phase", 32'(phase), 32'd5);
    for (int c = 0; c < 20; c++) begin
      run_cycle($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      chk("hlt_frozen_strobes", 32'(strobes()), 32'(9'b000000001));
    end
    chk("hlt_icnt", 32'(icnt), 32'd1);
    do_reset();
    chk("hlt_cleared", 32'(halt), 32'd0);

    // Reset during STO phase 7 kills wr immediately; restart from phase 0.
    for (int p = 0; p < 7; p++) run_cycle(6, 1'b0);
    opcode = 3'd6;
    #1;
    chk("abort_wr_before", 32'(wr), 32'd1);
    rst_ = 1'b0;
    #1;
    chk("abort_wr_after", 32'(wr), 32'd0);
    chk("abort_strobes", 32'(strobes()), 32'(9'b100000000));
    @(posedge clk);
    #2;
    rst_ = 1'b1;
    m_ph = 0; m_halted = 1'b0; m_cnt = 0;
    run_instr(6, 1'b0);

    // Counter saturation on the ICNT_W=2 instance.
    do_reset();
    for (int n = 0; n < 5; n++) run_instr(2, 1'($urandom_range(0, 1)));
    chk("sat_icnt2", 32'(s_icnt), 32'd3);
    chk("sat_icnt16", 32'(icnt), 32'd5);

    // Random instruction stream against the model.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      run_instr($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      if (m_halted) begin
        for (int c = 0; c < 4; c++) run_cycle($urandom_range(0, 7), 1'($urandom_range(0, 1)));
        do_reset();
      end
    end

`ifdef STEP_EN
    do_reset();
    step_mode = 1'b1;
    step = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk("step_hold_phase", 32'(phase), 32'd0);
    end
    opcode = 3'd5;
    step = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
    end
    step = 1'b0;
    #1;
    chk("step_phase4", 32'(phase), 32'd4);
    chk("step_inc_pc_gated", 32'(inc_pc), 32'd0);
    step = 1'b1;
    #1;
    chk("step_inc_pc_on", 32'(inc_pc), 32'd1);
    @(posedge clk);
    #1;
    chk("step_phase5", 32'(phase), 32'd5);
    step_mode = 1'b0;
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
